// File: rtl/ball_controller_if.sv
// Pong game-side bus: paddle/serve inputs toward the ball controller, ball and score outputs back.
// slave is the ball controller's view; master is the driver/consumer side.
interface ball_controller_if;
  logic       serve_n;
  logic       bat_size;
  logic [9:0] p1_y;
  logic [9:0] p2_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       point;
  logic       game_over;

  modport master (
    output serve_n, bat_size, p1_y, p2_y,
    input  ball_x, ball_y, score1, score2, point, game_over
  );

  modport slave (
    input  serve_n, bat_size, p1_y, p2_y,
    output ball_x, ball_y, score1, score2, point, game_over
  );
endinterface

// File: rtl/ball_controller.sv
// Pong ball/score engine: state and ball advance once per TICK_DIV cycles; point pulses the cycle after a miss tick.
// No backpressure; inputs are sampled only on tick cycles.
module ball_controller #(
  parameter int TICK_DIV  = 131072,
  parameter int STEP      = 2,
  parameter int BALL_HALF = 4,
  parameter int P1_X      = 24,
  parameter int P2_X      = 616,
  parameter int WIN_SCORE = 9
) (
  input  logic              clk,
  input  logic              rst,
  ball_controller_if.slave  bus
);

  localparam logic [16:0] TICK_LAST = 17'(TICK_DIV - 1);
  localparam logic [9:0]  STEP_W    = 10'(STEP);
  localparam logic [9:0]  HALF_W    = 10'(BALL_HALF);
  localparam logic [9:0]  X_L       = 10'(P1_X + BALL_HALF);
  localparam logic [9:0]  X_R       = 10'(P2_X - BALL_HALF);
  localparam logic [9:0]  Y_MAX     = 10'(479 - BALL_HALF);
  localparam logic [9:0]  X_MID     = 10'd320;
  localparam logic [9:0]  Y_MID     = 10'd240;
  localparam logic [3:0]  WIN_W     = 4'(WIN_SCORE);

  typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_t;

  state_t      state;
  logic [16:0] tick_cnt;
  logic        dx_right;
  logic        dy_down;

  logic        tick;
  logic [9:0]  reach;
  logic [9:0]  dist1;
  logic [9:0]  dist2;
  logic        hit1;
  logic        hit2;
  logic        edge_l;
  logic        edge_r;
  logic [9:0]  y_nxt;
  logic        dy_nxt;

  always_comb begin
    tick   = (tick_cnt == TICK_LAST);
    reach  = (bus.bat_size ? 10'd40 : 10'd50) + HALF_W;
    dist1  = (bus.ball_y > bus.p1_y) ? bus.ball_y - bus.p1_y : bus.p1_y - bus.ball_y;
    dist2  = (bus.ball_y > bus.p2_y) ? bus.ball_y - bus.p2_y : bus.p2_y - bus.ball_y;
    hit1   = (dist1 <= reach);
    hit2   = (dist2 <= reach);
    edge_l = !dx_right && (bus.ball_x <= X_L + STEP_W);
    edge_r =  dx_right && (bus.ball_x >= X_R - STEP_W);
    y_nxt  = bus.ball_y;
    dy_nxt = dy_down;
    if (dy_down) begin
      if (bus.ball_y + STEP_W >= Y_MAX) begin
        y_nxt  = Y_MAX;
        dy_nxt = 1'b0;
      end else begin
        y_nxt  = bus.ball_y + STEP_W;
      end
    end else begin
      // Compare before subtracting so the top wall never underflows.
      if (bus.ball_y <= HALF_W + STEP_W) begin
        y_nxt  = HALF_W;
        dy_nxt = 1'b1;
      end else begin
        y_nxt  = bus.ball_y - STEP_W;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= SERVE;
      tick_cnt      <= '0;
      dx_right      <= 1'b1;
      dy_down       <= 1'b1;
      bus.ball_x    <= X_MID;
      bus.ball_y    <= Y_MID;
      bus.score1    <= '0;
      bus.score2    <= '0;
      bus.point     <= 1'b0;
      bus.game_over <= 1'b0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 17'd1;
      bus.point <= 1'b0;
      if (tick) begin
        case (state)
          SERVE: begin
            bus.ball_x <= X_MID;
            bus.ball_y <= Y_MID;
            if (!bus.serve_n) state <= PLAY;
          end
          PLAY: begin
            bus.ball_y <= y_nxt;
            dy_down    <= dy_nxt;
            // On a miss dx is left alone: it already points at the conceding side.
            if (edge_l) begin
              if (hit1) begin
                bus.ball_x <= X_L;
                dx_right   <= 1'b1;
              end else begin
                bus.score2 <= bus.score2 + 4'd1;
                bus.point  <= 1'b1;
                state      <= POINT;
              end
            end else if (edge_r) begin
              if (hit2) begin
                bus.ball_x <= X_R;
                dx_right   <= 1'b0;
              end else begin
                bus.score1 <= bus.score1 + 4'd1;
                bus.point  <= 1'b1;
                state      <= POINT;
              end
            end else begin
              bus.ball_x <= dx_right ? bus.ball_x + STEP_W : bus.ball_x - STEP_W;
            end
          end
          POINT: begin
            bus.ball_x <= X_MID;
            bus.ball_y <= Y_MID;
            if (bus.score1 == WIN_W || bus.score2 == WIN_W) begin
              state         <= OVER;
              bus.game_over <= 1'b1;
            end else begin
              state <= SERVE;
            end
          end
          OVER: begin
            bus.ball_x <= X_MID;
            bus.ball_y <= Y_MID;
            if (!bus.serve_n) begin
              bus.score1    <= '0;
              bus.score2    <= '0;
              bus.game_over <= 1'b0;
              state         <= SERVE;
            end
          end
          default: state <= SERVE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_controller.sv
// Randomised bench for ball_controller: a per-cycle integer model of the game rules is compared against every output.
module tb_ball_controller;
  localparam int TDIV = 4;

  logic clk;
  logic rst;
  ball_controller_if bif();

  ball_controller #(.TICK_DIV(TDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0 serve, 1 play, 2 point, 3 over.
  int m_bx, m_by, m_s1, m_s2, m_mode, m_cnt;
  bit m_right, m_down, m_pt;
  int seen_over = 0;
  int seen_hit  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic m_reset();
    m_bx = 320; m_by = 240; m_s1 = 0; m_s2 = 0; m_mode = 0; m_cnt = 0;
    m_right = 1; m_down = 1; m_pt = 0;
  endtask

  task automatic m_step(input bit sn, input bit bs, input int p1, input int p2);
    int reach, ny;
    bit tick;
    tick  = (m_cnt == TDIV - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    m_pt  = 0;
    if (!tick) return;
    reach = (bs ? 40 : 50) + 4;
    case (m_mode)
      0: begin
        m_bx = 320; m_by = 240;
        if (!sn) m_mode = 1;
      end
      1: begin
        ny = m_down ? m_by + 2 : m_by - 2;
        if (m_down && ny >= 475) begin ny = 475; m_down = 0; end
        else if (!m_down && m_by <= 6) begin ny = 4; m_down = 1; end
        if (!m_right && m_bx <= 30) begin
          if (iabs(m_by - p1) <= reach) begin m_bx = 28; m_right = 1; seen_hit++; end
          else begin m_s2++; m_pt = 1; m_mode = 2; end
        end else if (m_right && m_bx >= 610) begin
          if (iabs(m_by - p2) <= reach) begin m_bx = 612; m_right = 0; seen_hit++; end
          else begin m_s1++; m_pt = 1; m_mode = 2; end
        end else begin
          m_bx = m_right ? m_bx + 2 : m_bx - 2;
        end
        m_by = ny;
      end
      2: begin
        m_bx = 320; m_by = 240;
        m_mode = (m_s1 == 9 || m_s2 == 9) ? 3 : 0;
        if (m_mode == 3) seen_over++;
      end
      default: begin
        m_bx = 320; m_by = 240;
        if (!sn) begin m_s1 = 0; m_s2 = 0; m_mode = 0; end
      end
    endcase
  endtask

  task automatic compare_all();
    check("ball_x", int'(bif.ball_x), m_bx);
    check("ball_y", int'(bif.ball_y), m_by);
    check("score1", int'(bif.score1), m_s1);
    check("score2", int'(bif.score2), m_s2);
    check("point", int'(bif.point), int'(m_pt));
    check("game_over", int'(bif.game_over), (m_mode == 3) ? 1 : 0);
  endtask

  function automatic int paddle_near(input int y);
    int p;
    p = y + int'($urandom_range(0, 140)) - 70;
    return (p < 0) ? 0 : p;
  endfunction

  // Drive one cycle's inputs at the falling edge, advance the model across the rising edge, compare at the next fall.
  task automatic run_cycle(input bit hold_serve);
    bit sn, bs;
    int p1, p2;
    sn = hold_serve ? 1'b1 : ($urandom_range(0, 2) != 0);
    bs = 1'($urandom_range(0, 1));
    p1 = ($urandom_range(0, 3) != 0) ? paddle_near(m_by) : int'($urandom_range(0, 479));
    p2 = ($urandom_range(0, 3) != 0) ? paddle_near(m_by) : int'($urandom_range(0, 479));
    bif.serve_n  = sn;
    bif.bat_size = bs;
    bif.p1_y     = 10'(p1);
    bif.p2_y     = 10'(p2);
    m_step(sn, bs, p1, p2);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    bit found;
    rst = 1'b0;
    bif.serve_n = 1'b1; bif.bat_size = 1'b0; bif.p1_y = 10'd240; bif.p2_y = 10'd240;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b1;

    for (int i = 0; i < 40; i++) run_cycle(1'b1);
    for (int i = 0; i < 40000; i++) run_cycle(1'b0);
    check("game_reached_over", (seen_over > 0) ? 1 : 0, 1);
    check("paddle_hits_seen", (seen_hit > 0) ? 1 : 0, 1);

    // Abort a rally in progress with an asynchronous reset between edges.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      if (m_mode == 1 && m_bx != 320) found = 1'b1;
      else run_cycle(1'b0);
    end
    check("reached_play", int'(found), 1);
    #2 rst = 1'b0;
    #1;
    m_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    rst = 1'b1;
    for (int i = 0; i < 400; i++) run_cycle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
